// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-segment 7-segment scanner with frame-synchronous shadow
// capture, anti-ghosting blanking at the start of each slot, PWM brightness and hex decode.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           digit_data,
  input  logic [7:0]            dp_mask,
  input  logic [7:0]            digit_en,
  input  logic [3:0]            brightness,
  input  logic                  load,
  output logic                  load_ack,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_INV     = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_INV    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_INV     = ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  // Segment pattern in gfedcba order, logical (active-high) polarity.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'b0111111;
      4'h1:    pattern = 7'b0000110;
      4'h2:    pattern = 7'b1011011;
      4'h3:    pattern = 7'b1001111;
      4'h4:    pattern = 7'b1100110;
      4'h5:    pattern = 7'b1101101;
      4'h6:    pattern = 7'b1111101;
      4'h7:    pattern = 7'b0000111;
      4'h8:    pattern = 7'b1111111;
      4'h9:    pattern = 7'b1101111;
      4'hA:    pattern = 7'b1110111;
      4'hB:    pattern = 7'b1111100;
      4'hC:    pattern = 7'b0111001;
      4'hD:    pattern = 7'b1011110;
      4'hE:    pattern = 7'b1111001;
      4'hF:    pattern = 7'b1110001;
      default: pattern = 7'b0000000;
    endcase
    return pattern;
  endfunction

  state_t                    state_r;
  state_t                    state_nx;
  logic [CNT_W-1:0]          slot_r;
  logic [CNT_W-1:0]          slot_nx;
  logic [IDX_W-1:0]          idx_r;
  logic [IDX_W-1:0]          idx_nx;
  logic [3:0]                pwm_r;
  logic                      pending_r;
  logic                      pending_nx;
  logic                      capture_s;
  logic                      frame_end_s;

  logic [4*NUM_DIGITS-1:0]   digit_sh_r;
  logic [NUM_DIGITS-1:0]     dp_sh_r;
  logic [NUM_DIGITS-1:0]     en_sh_r;
  logic [3:0]                bright_sh_r;

  logic [3:0]                nibble_s;
  logic [NUM_DIGITS-1:0]     an_s;
  logic [6:0]                seg_s;
  logic                      dp_s;

  logic [NUM_DIGITS-1:0]     an_r;
  logic [6:0]                seg_r;
  logic                      dp_r;
  logic                      load_ack_r;
  logic                      frame_done_r;

  // Register-file lanes above NUM_DIGITS are deliberately dropped.
  logic                      unused_lanes_s;
  assign unused_lanes_s = ^{digit_data, dp_mask, digit_en};

  // Nibble of the digit currently being scanned.
  always_comb begin
    nibble_s = digit_sh_r[{idx_r, 2'b00} +: 4];
  end

  // Next-state, slot sequencing, capture decision and logical display outputs.
  always_comb begin
    state_nx    = state_r;
    slot_nx     = slot_r;
    idx_nx      = idx_r;
    capture_s   = 1'b0;
    frame_end_s = 1'b0;
    an_s        = {NUM_DIGITS{1'b0}};
    seg_s       = 7'h00;
    dp_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        capture_s = 1'b1;
        state_nx  = ST_BLANK;
        slot_nx   = {CNT_W{1'b0}};
        idx_nx    = {IDX_W{1'b0}};
      end
      ST_BLANK: begin
        seg_s   = hex_to_seg(nibble_s);
        dp_s    = dp_sh_r[idx_r];
        slot_nx = slot_r + CNT_W'(1);
        if (slot_r == BLANK_LAST) begin
          state_nx = ST_ON;
        end else begin
          state_nx = ST_BLANK;
        end
      end
      ST_ON: begin
        seg_s        = hex_to_seg(nibble_s);
        dp_s         = dp_sh_r[idx_r];
        an_s[idx_r]  = en_sh_r[idx_r] && (pwm_r <= bright_sh_r);
        if (slot_r == SLOT_LAST) begin
          state_nx = ST_BLANK;
          slot_nx  = {CNT_W{1'b0}};
          if (idx_r == IDX_LAST) begin
            // Frame boundary: a load arriving this very cycle is taken now too.
            idx_nx      = {IDX_W{1'b0}};
            frame_end_s = 1'b1;
            capture_s   = pending_r | load;
          end else begin
            idx_nx = idx_r + IDX_W'(1);
          end
        end else begin
          slot_nx = slot_r + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        slot_nx  = {CNT_W{1'b0}};
        idx_nx   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Pending-load bookkeeping: repeated loads collapse until the next capture.
  always_comb begin
    if (capture_s) begin
      pending_nx = 1'b0;
    end else begin
      pending_nx = pending_r | load;
    end
  end

  // Sequencer state, PWM phase and pending flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      slot_r    <= {CNT_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      pwm_r     <= 4'd0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      slot_r    <= slot_nx;
      idx_r     <= idx_nx;
      pwm_r     <= pwm_r + 4'd1;
      pending_r <= pending_nx;
    end
  end

  // Shadow copies of the register file, updated only on capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      digit_sh_r  <= {(4*NUM_DIGITS){1'b0}};
      dp_sh_r     <= {NUM_DIGITS{1'b0}};
      en_sh_r     <= {NUM_DIGITS{1'b0}};
      bright_sh_r <= 4'd0;
    end else if (capture_s) begin
      digit_sh_r  <= digit_data[4*NUM_DIGITS-1:0];
      dp_sh_r     <= dp_mask[NUM_DIGITS-1:0];
      en_sh_r     <= digit_en[NUM_DIGITS-1:0];
      bright_sh_r <= brightness;
    end else begin
      digit_sh_r  <= digit_sh_r;
      dp_sh_r     <= dp_sh_r;
      en_sh_r     <= en_sh_r;
      bright_sh_r <= bright_sh_r;
    end
  end

  // Pin registers; polarity is folded in before the flop so pins are glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      an_r         <= AN_INV;
      seg_r        <= SEG_INV;
      dp_r         <= DP_INV;
      load_ack_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_s ^ AN_INV;
      seg_r        <= seg_s ^ SEG_INV;
      dp_r         <= dp_s ^ DP_INV;
      load_ack_r   <= capture_s;
      frame_done_r <= frame_end_s;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign load_ack   = load_ack_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-position model pushes the expected
// registered outputs for each cycle, which are popped and compared after the edge.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         ack;
    logic         fd;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  digit_data;
  logic [7:0]   dp_mask;
  logic [7:0]   digit_en;
  logic [3:0]   brightness;
  logic         load;
  logic         load_ack;
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         dp;
  logic         frame_done;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .CLK_DIV     (DIV),
    .BLANK_CYCLES(BLANK),
    .ACTIVE_LOW  (1'b0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .digit_data(digit_data),
    .dp_mask   (dp_mask),
    .digit_en  (digit_en),
    .brightness(brightness),
    .load      (load),
    .load_ack  (load_ack),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cycle_no = 0;
  int   last_fd  = -1;
  int   ack_cnt  = 0;

  // Model state: running flag, position in frame, PWM phase, pending, shadows.
  bit          m_run  = 1'b0;
  int          m_t    = 0;
  int          m_pwm  = 0;
  bit          m_pend = 1'b0;
  logic [15:0] m_dig  = 16'h0;
  logic [3:0]  m_dp   = 4'h0;
  logic [3:0]  m_en   = 4'h0;
  logic [3:0]  m_br   = 4'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cycle_no, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_capture();
    m_dig = digit_data[15:0];
    m_dp  = dp_mask[3:0];
    m_en  = digit_en[3:0];
    m_br  = brightness;
  endtask

  task automatic tick();
    exp_t e;
    int   slot;
    int   pos;
    bit   bnd;
    bit   cap;
    e = '{an: '0, seg: '0, dp: 1'b0, ack: 1'b0, fd: 1'b0};
    if (reset) begin
      m_run  = 1'b0;
      m_t    = 0;
      m_pwm  = 0;
      m_pend = 1'b0;
    end else if (!m_run) begin
      e.ack = 1'b1;
      model_capture();
      m_pend = 1'b0;
      m_run  = 1'b1;
      m_t    = 0;
      m_pwm  = (m_pwm + 1) % 16;
    end else begin
      slot  = m_t / DIV;
      pos   = m_t % DIV;
      e.seg = SEG_TAB[m_dig[slot*4 +: 4]];
      e.dp  = m_dp[slot];
      if (pos >= BLANK && m_en[slot] && m_pwm <= int'(m_br)) e.an = 4'b0001 << slot;
      bnd   = (m_t == FRAME - 1);
      cap   = bnd && (m_pend || load);
      e.fd  = bnd;
      e.ack = cap;
      if (cap) begin
        model_capture();
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      m_t   = bnd ? 0 : m_t + 1;
      m_pwm = (m_pwm + 1) % 16;
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    cycle_no++;
    e = sb.pop_front();
    check_eq("an",         32'(an),         32'(e.an));
    check_eq("seg",        32'(seg),        32'(e.seg));
    check_eq("dp",         32'(dp),         32'(e.dp));
    check_eq("load_ack",   32'(load_ack),   32'(e.ack));
    check_eq("frame_done", 32'(frame_done), 32'(e.fd));
    if (load_ack) ack_cnt++;
    if (reset) begin
      last_fd = -1;
    end else if (frame_done) begin
      if (last_fd >= 0) check_eq("fd_period", 32'(cycle_no - last_fd), 32'(FRAME));
      last_fd = cycle_no;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int t);
    int guard;
    guard = 0;
    while (!(m_run && m_t == t) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check_eq("align_timeout", 32'(guard), 32'(0));
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    digit_data = 32'h0000_3210;
    dp_mask    = 8'h00;
    digit_en   = 8'h0F;
    brightness = 4'hF;
    run(3);

    // Release reset; the IDLE cycle captures and acks unconditionally.
    reset = 1'b0;
    pulse_load();
    run(70);

    // Mid-frame reload: ack must land on the frame boundary.
    run_to(10);
    digit_data = 32'h0000_FEDC;
    pulse_load();
    run(75);

    digit_en = 8'h05;
    pulse_load();
    run(70);

    digit_en   = 8'h0F;
    brightness = 4'h0;
    pulse_load();
    run(70);

    // Three loads inside one frame collapse into a single ack at the boundary.
    brightness = 4'hF;
    dp_mask    = 8'h02;
    digit_data = 32'h0000_9876;
    run_to(1);
    ack_cnt = 0;
    pulse_load();
    run(4);
    pulse_load();
    run(4);
    pulse_load();
    run_to(0);
    check_eq("ack_count", 32'(ack_cnt), 32'(1));
    run(40);

    // Reset during the ON window of slot 2, then watch the scan restart.
    digit_data = 32'h0000_BA54;
    pulse_load();
    run_to(0);
    run_to(2 * DIV + BLANK + 1);
    reset = 1'b1;
    tick();
    check_eq("rst_an",  32'(an),       32'(0));
    check_eq("rst_seg", 32'(seg),      32'(0));
    check_eq("rst_ack", 32'(load_ack), 32'(0));
    reset = 1'b0;
    run(70);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
